// File: rtl/wb_arbiter.sv
`default_nettype none
// =====================================================================
// wb_arbiter : owns the register-file write port; merges ALU results
//              with FIFO-queued long-latency results, tracks pending regs
// Revision   : 1.0
// =====================================================================
module wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       alu_wren_i,
    input  logic [4:0]                 alu_addr_i,
    input  logic [31:0]                alu_data_i,
    input  logic                       lsu_valid_i,
    output logic                       lsu_ready_o,
    input  logic [4:0]                 lsu_addr_i,
    input  logic [31:0]                lsu_data_i,
    input  logic                       issue_i,
    input  logic [4:0]                 issue_addr_i,
    output logic                       rd_wren_o,
    output logic [4:0]                 rd_addr_o,
    output logic [31:0]                rd_data_o,
    output logic [31:0]                busy_o,
    output logic                       stall_o,
    output logic                       err_o,
    output logic [$clog2(DEPTH):0]     fifo_count_o
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_stv_w = $clog2(STARVE_MAX + 1);
    localparam logic [c_cnt_w-1:0] c_depth      = c_cnt_w'(DEPTH);
    localparam logic [c_stv_w-1:0] c_starve_max = c_stv_w'(STARVE_MAX);

    logic [4:0]         r_mem_addr [DEPTH];
    logic [31:0]        r_mem_data [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [c_stv_w-1:0] r_starve;
    logic               r_stall;
    logic               r_err;
    logic [31:0]        r_busy;
    logic               r_rd_wren;
    logic               r_rd_fifo;
    logic [4:0]         r_rd_addr;
    logic [31:0]        r_rd_data;

    logic               w_ready;
    logic               w_empty;
    logic               w_alu_sel;
    logic               w_push;
    logic               w_pop;
    logic [c_cnt_w-1:0] w_count_nxt;
    logic [c_stv_w-1:0] w_starve_nxt;
    logic [31:0]        w_busy_nxt;

    always_comb begin
        w_ready     = (r_count < c_depth);
        w_empty     = (r_count == '0);
        w_alu_sel   = alu_wren_i && (alu_addr_i != 5'd0);
        // x0 pushes complete the handshake but are dropped
        w_push      = lsu_valid_i && w_ready && (lsu_addr_i != 5'd0);
        w_pop       = !w_alu_sel && !w_empty;
        w_count_nxt = r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);

        w_starve_nxt = '0;
        if (w_alu_sel && !w_empty) begin
            w_starve_nxt = (r_starve == c_starve_max) ? r_starve : r_starve + c_stv_w'(1);
        end

        // clear follows the FIFO-sourced write by one cycle; a same-edge issue wins
        w_busy_nxt = r_busy;
        if (r_rd_wren && r_rd_fifo) begin
            w_busy_nxt[r_rd_addr] = 1'b0;
        end
        if (issue_i && (issue_addr_i != 5'd0)) begin
            w_busy_nxt[issue_addr_i] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= lsu_addr_i;
            r_mem_data[r_wr_ptr] <= lsu_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_starve  <= '0;
            r_stall   <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= '0;
            r_rd_wren <= 1'b0;
            r_rd_fifo <= 1'b0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count  <= w_count_nxt;
            r_starve <= w_starve_nxt;
            r_busy   <= w_busy_nxt;

            if (w_count_nxt == '0) begin
                r_stall <= 1'b0;
            end else if (w_starve_nxt == c_starve_max) begin
                r_stall <= 1'b1;
            end

            if (r_stall && w_alu_sel) begin
                r_err <= 1'b1;
            end

            r_rd_wren <= w_alu_sel || w_pop;
            r_rd_fifo <= w_pop;
            if (w_alu_sel) begin
                r_rd_addr <= alu_addr_i;
                r_rd_data <= alu_data_i;
            end else if (w_pop) begin
                r_rd_addr <= r_mem_addr[r_rd_ptr];
                r_rd_data <= r_mem_data[r_rd_ptr];
            end
        end
    end

    assign lsu_ready_o  = w_ready;
    assign rd_wren_o    = r_rd_wren;
    assign rd_addr_o    = r_rd_addr;
    assign rd_data_o    = r_rd_data;
    assign busy_o       = r_busy;
    assign stall_o      = r_stall;
    assign err_o        = r_err;
    assign fifo_count_o = r_count;

endmodule
`default_nettype wire
